// File: rtl/dsp_pkg.sv
// Shared widths and operation selectors for the dsp_block multiply-add slice.
package dsp_pkg;
    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int D_W = 18;
    localparam int C_W = 48;
    localparam int P_W = 48;
    localparam int M_W = 36;

    // OPERATION is an untyped string parameter, so compare it as packed 3-char text.
    localparam logic [23:0] OP_ADD = "ADD";
    localparam logic [23:0] OP_SUB = "SUB";
endpackage

// File: rtl/dsp_pipe_reg.sv
// Parameterized-width pipeline register with synchronous active-high clear.
module dsp_pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge clk) begin
        if (i_clr) o_q <= '0;
        else       o_q <= i_d;
    end
endmodule

// File: rtl/dsp_block.sv
// Four-stage pre-add / multiply / post-add slice: P = C +/- ((D +/- B) * A), unsigned, modular.
module dsp_block
    import dsp_pkg::*;
#(
    parameter OPERATION = "ADD"
) (
    input  logic           clk,
    input  logic           rst_n,  // active-high synchronous reset despite the name
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [C_W-1:0] c,
    input  logic [D_W-1:0] d,
    output logic [P_W-1:0] p
);
    logic [A_W-1:0] w_a1, w_a2;
    logic [B_W-1:0] w_b1;
    logic [C_W-1:0] w_c1, w_c2, w_c3;
    logic [D_W-1:0] w_d1;
    logic [D_W-1:0] w_pre_nxt, w_pre;
    logic [M_W-1:0] w_prod;
    logic [P_W-1:0] w_m_nxt, w_m;
    logic [P_W-1:0] w_p_nxt;

    // Stage 1: input registers
    dsp_pipe_reg #(.W(A_W)) u_a1 (.clk(clk), .i_clr(rst_n), .i_d(a), .o_q(w_a1));
    dsp_pipe_reg #(.W(B_W)) u_b1 (.clk(clk), .i_clr(rst_n), .i_d(b), .o_q(w_b1));
    dsp_pipe_reg #(.W(C_W)) u_c1 (.clk(clk), .i_clr(rst_n), .i_d(c), .o_q(w_c1));
    dsp_pipe_reg #(.W(D_W)) u_d1 (.clk(clk), .i_clr(rst_n), .i_d(d), .o_q(w_d1));

    // Any OPERATION other than "SUB" falls back to ADD.
    generate
        if (OPERATION == OP_SUB) begin : g_sub
            assign w_pre_nxt = w_d1 - w_b1;
            assign w_p_nxt   = w_c3 - w_m;
        end else begin : g_add
            assign w_pre_nxt = w_d1 + w_b1;
            assign w_p_nxt   = w_c3 + w_m;
        end
    endgenerate

    // Stage 2: pre-adder (mod 2^18), delay A and C
    dsp_pipe_reg #(.W(D_W)) u_pre (.clk(clk), .i_clr(rst_n), .i_d(w_pre_nxt), .o_q(w_pre));
    dsp_pipe_reg #(.W(A_W)) u_a2  (.clk(clk), .i_clr(rst_n), .i_d(w_a1),      .o_q(w_a2));
    dsp_pipe_reg #(.W(C_W)) u_c2  (.clk(clk), .i_clr(rst_n), .i_d(w_c1),      .o_q(w_c2));

    // Stage 3: full 36-bit product, zero-extended to the accumulator width
    assign w_prod  = M_W'(w_pre) * M_W'(w_a2);
    assign w_m_nxt = P_W'(w_prod);

    dsp_pipe_reg #(.W(P_W)) u_m  (.clk(clk), .i_clr(rst_n), .i_d(w_m_nxt), .o_q(w_m));
    dsp_pipe_reg #(.W(C_W)) u_c3 (.clk(clk), .i_clr(rst_n), .i_d(w_c2),    .o_q(w_c3));

    // Stage 4: post-adder (mod 2^48) straight into the output register
    dsp_pipe_reg #(.W(P_W)) u_p (.clk(clk), .i_clr(rst_n), .i_d(w_p_nxt), .o_q(p));
endmodule

// File: tb/tb_dsp_block.sv
// Directed and random checks of ADD and SUB dsp_block instances driven with shared operands.
module tb_dsp_block;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic [47:0] p_add, p_sub;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Expected-result delay line per instance; index 3 is what p must show now.
    logic [47:0] m_add [4];
    logic [47:0] m_sub [4];

    always #5 clk = ~clk;

    dsp_block #(.OPERATION("ADD")) u_add (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p_add)
    );
    dsp_block #(.OPERATION("SUB")) u_sub (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p_sub)
    );

    function automatic logic [47:0] ref_p(input bit sub, input logic [17:0] fa, fb, fd,
                                          input logic [47:0] fc);
        logic [17:0] pre;
        logic [47:0] m;
        pre = sub ? (fd - fb) : (fd + fb);
        m   = {30'd0, pre} * {30'd0, fa};
        return sub ? (fc - m) : (fc + m);
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operand set for one edge, advance the reference, check at the negedge.
    task automatic tick(input logic r, input logic [17:0] ta, tb_, td, input logic [47:0] tc);
        rst_n = r; a = ta; b = tb_; d = td; c = tc;
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
            m_add[i] = r ? 48'd0 : m_add[i-1];
            m_sub[i] = r ? 48'd0 : m_sub[i-1];
        end
        m_add[0] = r ? 48'd0 : ref_p(1'b0, ta, tb_, td, tc);
        m_sub[0] = r ? 48'd0 : ref_p(1'b1, ta, tb_, td, tc);
        @(negedge clk);
        chk("stream_add", p_add, m_add[3]);
        chk("stream_sub", p_sub, m_sub[3]);
    endtask

    task automatic rnd_tick(input logic r);
        logic [47:0] rc;
        rc = {16'($urandom), $urandom};
        tick(r, 18'($urandom), 18'($urandom), 18'($urandom), rc);
    endtask

    // One vector, three idle edges, then compare against hand-computed results.
    task automatic directed(input string tag, input logic [17:0] ta, tb_, td,
                            input logic [47:0] tc, input logic [47:0] e_add, e_sub);
        tick(1'b0, ta, tb_, td, tc);
        repeat (3) tick(1'b0, 18'd0, 18'd0, 18'd0, 48'd0);
        chk({tag, "_add"}, p_add, e_add);
        chk({tag, "_sub"}, p_sub, e_sub);
    endtask

    initial begin
        logic [17:0] va, vb, vd;
        logic [47:0] vc;
        for (int i = 0; i < 4; i++) begin
            m_add[i] = '0;
            m_sub[i] = '0;
        end
        rst_n = 1'b1; a = '0; b = '0; c = '0; d = '0;
        @(negedge clk);

        // Reset hold with random inputs
        for (int i = 0; i < 100; i++) begin
            rnd_tick(1'b1);
            chk("rst_hold_add", p_add, 48'd0);
            chk("rst_hold_sub", p_sub, 48'd0);
        end

        // Directed vectors (hand-computed)
        directed("basic1",   18'd2, 18'd3, 18'd4, 48'd10,
                 48'd24, 48'd8);
        directed("basic2",   18'd5, 18'd3, 18'd10, 48'd100,
                 48'd165, 48'd65);
        directed("post_wrap", 18'd1, 18'd0, 18'd1, 48'd0,
                 48'd1, 48'hFFFF_FFFF_FFFF);
        directed("pre_wrap1", 18'd7, 18'd1, 18'h3FFFF, 48'd5,
                 48'd5, 48'hFFFF_FFE4_0013);
        directed("pre_wrap2", 18'd1, 18'd1, 18'd0, 48'd0,
                 48'd1, 48'hFFFF_FFFC_0001);
        directed("max_prod", 18'h3FFFF, 18'd0, 18'h3FFFF, 48'd0,
                 48'h000F_FFF8_0001, 48'hFFF0_0007_FFFF);

        // Random back-to-back stream
        for (int i = 0; i < 60; i++) rnd_tick(1'b0);

        // Mid-stream reset for one edge, then a known vector right after release
        tick(1'b1, 18'h1234, 18'h0567, 18'h2222, 48'h1111_2222_3333);
        chk("midrst_add", p_add, 48'd0);
        chk("midrst_sub", p_sub, 48'd0);
        va = 18'h2AAAA; vb = 18'h15555; vd = 18'h3F00F; vc = 48'hDEAD_BEEF_0123;
        tick(1'b0, va, vb, vd, vc);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_zero_add", p_add, 48'd0);
            chk("post_rst_zero_sub", p_sub, 48'd0);
            rnd_tick(1'b0);
        end
        chk("post_rst_first_add", p_add, ref_p(1'b0, va, vb, vd, vc));
        chk("post_rst_first_sub", p_sub, ref_p(1'b1, va, vb, vd, vc));

        for (int i = 0; i < 20; i++) rnd_tick(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
